// File: rtl/fixedpoint_pkg.sv
// Shared fixed-point definitions for the BKM logarithm pipeline.
//   number          : signed Q23.40 value (64 bits, 40 fractional bits)
//   LOG2_TABLE[i]   : log2(1 + 2^-i), i = 0..31, as number
//   LN2             : ln(2) as number
//   msb_index()     : leading-one priority encoder over a number
//   from_int()      : signed integer -> number
package fixedpoint;

   localparam int fractional_bits = 40;
   localparam int number_bits     = 64;

   typedef logic signed [number_bits-1:0] number;
   typedef logic [31:0][number_bits-1:0]  log2_table_t;

   localparam number ONE = number'(64'd1 << fractional_bits);

   // Bitwise log2 by repeated squaring of (1 + 2^-i) held in Q2.62.
   // Each squaring doubles the exponent; a result >= 2 yields a one bit.
   function automatic log2_table_t build_log2_table();
      log2_table_t       tbl;
      logic [127:0]      x;
      logic [63:0]       acc;
      tbl    = '0;
      tbl[0] = 64'd1 << fractional_bits;
      for (int i = 1; i < 32; i++) begin
         x   = (128'd1 << 62) + (128'd1 << (62 - i));
         acc = '0;
         for (int j = 1; j <= fractional_bits; j++) begin
            x = (x * x) >> 62;
            if (x >= (128'd1 << 63)) begin
               acc = acc | (64'd1 << (fractional_bits - j));
               x   = x >> 1;
            end
         end
         tbl[5'(i)] = acc;
      end
      return tbl;
   endfunction

   // ln2 = sum 1/(n*2^n), accumulated in Q100 then rounded to Q40.
   function automatic number calc_ln2();
      logic [127:0] acc;
      acc = '0;
      for (int n = 1; n <= 60; n++)
         acc = acc + ((128'd1 << (100 - n)) / 128'(n));
      return number'(64'((acc + (128'd1 << 59)) >> 60));
   endfunction

   localparam log2_table_t LOG2_TABLE = build_log2_table();
   localparam number       LN2        = calc_ln2();

   function automatic logic [5:0] msb_index(input number v);
      logic [5:0] idx;
      idx = '0;
      for (int i = 0; i < number_bits; i++)
         if (v[6'(i)]) idx = 6'(i);
      return idx;
   endfunction

   function automatic number from_int(input logic signed [7:0] k);
      return number'(k) <<< fractional_bits;
   endfunction

endpackage

// File: rtl/bkm_log_stage.sv
// One registered BKM iteration with shift index I.
//   clk, rst            : clock, async active-high reset
//   valid/mode/err/tag  : per-sample sideband, registered through
//   x, y, v, k          : running product, running log, normalised operand, exponent
//   *_q                 : registered outputs toward the next stage
module bkm_log_stage
   import fixedpoint::*;
#(
   parameter int I     = 0,
   parameter int TAG_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid,
   input  logic               mode,
   input  logic               err,
   input  logic [TAG_W-1:0]   tag,
   input  number              x,
   input  number              y,
   input  number              v,
   input  logic signed [7:0]  k,
   output logic               valid_q,
   output logic               mode_q,
   output logic               err_q,
   output logic [TAG_W-1:0]   tag_q,
   output number              x_q,
   output number              y_q,
   output number              v_q,
   output logic signed [7:0]  k_q
);

   localparam number STEP = number'(LOG2_TABLE[I]);

   number t;
   logic  take;

   assign t    = x + (x >>> I);
   assign take = (t <= v);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         mode_q  <= 1'b0;
         err_q   <= 1'b0;
         tag_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         v_q     <= '0;
         k_q     <= '0;
      end else begin
         valid_q <= valid;
         mode_q  <= mode;
         err_q   <= err;
         tag_q   <= tag;
         v_q     <= v;
         k_q     <= k;
         x_q     <= take ? t : x;
         y_q     <= take ? y + STEP : y;
      end
   end

endmodule

// File: rtl/bkm_log_unit.sv
// Fully pipelined log2 / ln unit using BKM iterations, latency STAGES+4.
//   clk, rst                 : clock, async active-high reset
//   in_valid/value/mode/tag  : sample input (mode 0 = log2, 1 = ln)
//   out_valid/log/err/tag    : result; err flags operand <= 0, all zero when idle
// Pipeline: capture -> normalise -> STAGES x iteration -> denormalise -> scale.
module bkm_log_unit
   import fixedpoint::*;
#(
   parameter int STAGES = 28,
   parameter int TAG_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  number            in_value,
   input  logic             in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   output number            out_log,
   output logic             out_err,
   output logic [TAG_W-1:0] out_tag
);

   // capture
   logic             s0_valid, s0_mode, s0_err;
   number            s0_value;
   logic [TAG_W-1:0] s0_tag;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_valid <= 1'b0;
         s0_mode  <= 1'b0;
         s0_err   <= 1'b0;
         s0_value <= '0;
         s0_tag   <= '0;
      end else begin
         s0_valid <= in_valid;
         s0_mode  <= in_mode;
         s0_err   <= (in_value <= 0);
         s0_value <= in_value;
         s0_tag   <= in_tag;
      end
   end

   // normalise into [1.0, 2.0); k is the binary exponent removed
   logic [5:0]        msb;
   logic signed [7:0] k_c;
   number             v_c;

   assign msb = msb_index(s0_value);
   assign k_c = 8'(msb) - 8'(fractional_bits);

   always_comb begin
      v_c = s0_value >> k_c;
      if (k_c[7]) v_c = s0_value << (-k_c);
   end

   logic              n_valid, n_mode, n_err;
   logic [TAG_W-1:0]  n_tag;
   number             n_v;
   logic signed [7:0] n_k;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_valid <= 1'b0;
         n_mode  <= 1'b0;
         n_err   <= 1'b0;
         n_tag   <= '0;
         n_v     <= '0;
         n_k     <= '0;
      end else begin
         n_valid <= s0_valid;
         n_mode  <= s0_mode;
         n_err   <= s0_err;
         n_tag   <= s0_tag;
         n_v     <= v_c;
         n_k     <= k_c;
      end
   end

   // iteration chain; index 0 is the normalised sample with x = 1.0, y = 0
   logic [STAGES:0]            vld_pipe, mode_pipe, err_pipe;
   logic [STAGES:0][TAG_W-1:0] tag_pipe;
   number                      x_pipe [0:STAGES];
   number                      y_pipe [0:STAGES];
   number                      v_pipe [0:STAGES];
   logic signed [7:0]          k_pipe [0:STAGES];

   assign vld_pipe[0]  = n_valid;
   assign mode_pipe[0] = n_mode;
   assign err_pipe[0]  = n_err;
   assign tag_pipe[0]  = n_tag;
   assign x_pipe[0]    = ONE;
   assign y_pipe[0]    = '0;
   assign v_pipe[0]    = n_v;
   assign k_pipe[0]    = n_k;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      bkm_log_stage #(.I(i), .TAG_W(TAG_W)) u_stage (
         .clk     (clk),
         .rst     (rst),
         .valid   (vld_pipe[i]),
         .mode    (mode_pipe[i]),
         .err     (err_pipe[i]),
         .tag     (tag_pipe[i]),
         .x       (x_pipe[i]),
         .y       (y_pipe[i]),
         .v       (v_pipe[i]),
         .k       (k_pipe[i]),
         .valid_q (vld_pipe[i+1]),
         .mode_q  (mode_pipe[i+1]),
         .err_q   (err_pipe[i+1]),
         .tag_q   (tag_pipe[i+1]),
         .x_q     (x_pipe[i+1]),
         .y_q     (y_pipe[i+1]),
         .v_q     (v_pipe[i+1]),
         .k_q     (k_pipe[i+1])
      );
   end

   // denormalise: add back the exponent
   logic             d_valid, d_mode, d_err;
   logic [TAG_W-1:0] d_tag;
   number            d_log;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_valid <= 1'b0;
         d_mode  <= 1'b0;
         d_err   <= 1'b0;
         d_tag   <= '0;
         d_log   <= '0;
      end else begin
         d_valid <= vld_pipe[STAGES];
         d_mode  <= mode_pipe[STAGES];
         d_err   <= err_pipe[STAGES];
         d_tag   <= tag_pipe[STAGES];
         d_log   <= y_pipe[STAGES] + from_int(k_pipe[STAGES]);
      end
   end

   // scale: ln(x) = log2(x) * ln2, full-width product then truncate
   logic signed [127:0] prod;
   number               scaled;

   assign prod   = $signed(128'(d_log)) * $signed(128'(LN2));
   assign scaled = d_mode ? number'(64'(prod >>> fractional_bits)) : d_log;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_err   <= 1'b0;
         out_log   <= '0;
         out_tag   <= '0;
      end else begin
         out_valid <= d_valid;
         out_err   <= d_valid & d_err;
         out_log   <= (d_valid && !d_err) ? scaled : '0;
         out_tag   <= d_valid ? d_tag : '0;
      end
   end

endmodule

// File: tb/tb_bkm_log_unit.sv
// Randomised bench for bkm_log_unit. The reference is real-valued log2/ln of
// the operand; a queue delayed by LAT cycles gives the expected output stream.
module tb_bkm_log_unit;
   import fixedpoint::*;

   localparam int    STAGES   = 28;
   localparam int    TAG_W    = 8;
   localparam int    LAT      = STAGES + 4;
   localparam real   SCALE    = 1099511627776.0;  // 2^40
   localparam longint LOG2_TOL = (64'sd1 <<< (40 - (STAGES - 2))) + 1;
   localparam longint LN_TOL   = (64'sd1 <<< (40 - (STAGES - 3))) + 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b0;
   number            in_value = '0;
   logic             in_mode = 1'b0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   number            out_log;
   logic             out_err;
   logic [TAG_W-1:0] out_tag;

   bkm_log_unit #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_value  (in_value),
      .in_mode   (in_mode),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_log   (out_log),
      .out_err   (out_err),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit               valid;
      bit               mode;
      bit               exact;
      longint           value;
      logic [TAG_W-1:0] tag;
   } smp_t;

   smp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   task automatic chk(input string name, input longint obs, input longint exp,
                      input longint tol = 0);
      longint d;
      d = obs - exp;
      if (d < 0) d = -d;
      n_cmp++;
      if (d > tol) begin
         n_bad++;
         $display("FAIL %s cyc %0d: got %0d want %0d (tol %0d)", name, cyc, obs, exp, tol);
      end
   endtask

   function automatic real ref_log(input longint v, input bit mode);
      real r;
      r = real'(v) / SCALE;
      return mode ? $ln(r) : $ln(r) / $ln(2.0);
   endfunction

   // One cycle: check what is due now, then drive the next input.
   task automatic step(input bit r, input bit v, input bit m, input longint val,
                       input logic [TAG_W-1:0] t, input bit ex = 1'b0);
      smp_t   e;
      longint want;
      @(negedge clk);
      cyc++;
      if (q.size() == LAT) begin
         e = q.pop_front();
         chk("valid", longint'(out_valid), longint'(e.valid));
         if (!e.valid) begin
            chk("idle_log", out_log, 0);
            chk("idle_err", longint'(out_err), 0);
            chk("idle_tag", longint'(out_tag), 0);
         end else if (e.value <= 0) begin
            chk("err_flag", longint'(out_err), 1);
            chk("err_log", out_log, 0);
            chk("err_tag", longint'(out_tag), longint'(e.tag));
         end else begin
            want = longint'(ref_log(e.value, e.mode) * SCALE);
            chk("ok_flag", longint'(out_err), 0);
            chk("tag", longint'(out_tag), longint'(e.tag));
            chk(e.exact ? "exact" : (e.mode ? "ln" : "log2"), out_log, want,
                e.exact ? 0 : (e.mode ? LN_TOL : LOG2_TOL));
         end
      end
      rst      = r;
      in_valid = v;
      in_mode  = m;
      in_value = val;
      in_tag   = t;
      if (r) foreach (q[i]) q[i].valid = 1'b0;
      e.valid = v && !r;
      e.mode  = m;
      e.exact = ex;
      e.value = val;
      e.tag   = t;
      q.push_back(e);
   endtask

   initial begin
      smp_t             z;
      logic [63:0]      u;
      logic [TAG_W-1:0] tg;
      z = '{valid: 1'b0, mode: 1'b0, exact: 1'b0, value: 0, tag: '0};
      repeat (LAT) q.push_back(z);
      #1 rst = 1'b1;

      // reset held, input activity must be ignored
      for (int i = 0; i < 4; i++)
         step(1, 1, 0, longint'(ONE) * 4, TAG_W'(8'hA0 + i));

      // directed points
      step(0, 1, 0, longint'(ONE),            8'h11, 1);   // 1.0 -> 0
      step(0, 1, 0, longint'(ONE) * 8,        8'h12, 1);   // 8.0 -> 3
      step(0, 0, 0, 0,                        8'h00);
      step(0, 1, 0, longint'(ONE) / 2,        8'h13, 1);   // 0.5 -> -1
      step(0, 1, 0, longint'(64'd1 << 20),    8'h14, 1);   // 2^-20 -> -20
      step(0, 1, 1, longint'(ONE) * 3,        8'h15);      // ln 3
      step(0, 1, 0, longint'(ONE) * 3,        8'h16);      // log2 3
      step(0, 1, 0, 0,                        8'h17);      // zero -> err
      step(0, 1, 1, -longint'(ONE) * 2,       8'h18);      // -2.0 -> err
      step(0, 1, 0, longint'(ONE) * 5,        8'h19);      // unaffected
      step(0, 1, 1, longint'(ONE) * 8,        8'h1A);

      // random stream with bubbles
      tg = '0;
      for (int i = 0; i < 200; i++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++)
            step(0, 0, 1'($urandom), longint'({$urandom, $urandom}), TAG_W'($urandom));
         u = {$urandom, $urandom};
         u = u >> $urandom_range(1, 62);
         if (u == 0) u = 64'd1;
         step(0, 1, 1'($urandom), longint'(u), tg);
         tg++;
      end

      // reset with samples in flight
      for (int i = 0; i < 10; i++)
         step(0, 1, 0, longint'(ONE) * (i + 2), TAG_W'(8'hC0 + i));
      for (int i = 0; i < 3; i++)
         step(1, 1, 0, longint'(ONE) * 7, 8'hEE);
      for (int i = 0; i < 5; i++)
         step(0, 0, 0, 0, 8'h00);
      step(0, 1, 0, longint'(ONE) * 16, 8'hD0, 1);
      step(0, 1, 1, longint'(ONE) * 10, 8'hD1);

      repeat (LAT + 2) step(0, 0, 0, 0, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bkm_log_unit.md
BKM_LOG_UNIT -- requirements
Module: bkm_log_unit

Interface
REQ-001 SHALL have parameter STAGES, default 28: number of BKM iterations, legal range 8..32.
REQ-002 SHALL have parameter TAG_W, default 8: width of the sideband tag carried with each sample.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: a sample is presented this cycle.
REQ-006 SHALL have port in_value, input, fixedpoint::number: the operand.
REQ-007 SHALL have port in_mode, input, 1 bit: 0 selects log2, 1 selects natural log (ln).
REQ-008 SHALL have port in_tag, input, TAG_W bits: sideband data returned unchanged with the result.
REQ-009 SHALL have port out_valid, output, 1 bit: a result is presented this cycle.
REQ-010 SHALL have port out_log, output, fixedpoint::number: the result.
REQ-011 SHALL have port out_err, output, 1 bit: the operand was zero or negative.
REQ-012 SHALL have port out_tag, output, TAG_W bits: the tag of the sample being returned.

Function
REQ-013 SHALL be fully pipelined: one sample accepted every cycle, no backpressure, no ready signal.
REQ-014 SHALL produce each result exactly LAT = STAGES+4 cycles after acceptance (32 cycles at default).
REQ-015 SHALL carry valid, mode, tag and error per sample through every stage.
- Input bubbles are reproduced at the output.
- Sample order is preserved.
REQ-016 Stage 0 SHALL register the accepted sample and set err = (in_value <= 0).
REQ-017 Stage 1 SHALL perform normalisation.
- k = index of the most-significant one minus fixedpoint::fractional_bits (signed).
- Shift the operand left or right by |k| so the normalised value v lies in [1.0, 2.0).
REQ-018 Stage i, for i = 0..STAGES-1, SHALL perform one BKM iteration.
- Form t = x + (x >>> i).
- If t <= v: x <= t and y <= y + LOG2_TABLE[i]; otherwise x and y hold.
- Initial values: x = 1.0, y = 0.
REQ-019 The denormalise stage SHALL compute L = y + fromInt(k).
REQ-020 The scale stage SHALL output L in mode 0, and in mode 1 output (L * LN2) arithmetically shifted right by fractional_bits, truncated, full-width signed product.
REQ-021 When err is set, out_log SHALL be 0 and out_err SHALL be 1; otherwise out_err SHALL be 0.
REQ-022 While out_valid=0, out_log, out_err and out_tag SHALL be driven to 0.
REQ-023 Accuracy for valid operands SHALL be |out_log - exact| <= 2^-(STAGES-2) in log2 mode and <= 2^-(STAGES-3) in ln mode.
REQ-024 Powers of two SHALL produce exact integer results (v = 1.0, so y = 0).

Reset
REQ-025 While rst=1, every pipeline valid bit SHALL be 0 and out_valid, out_log, out_err, out_tag SHALL all be 0, asynchronously.
REQ-026 Samples in flight when rst asserts SHALL be discarded, never emitted.
REQ-027 in_valid SHALL be ignored while rst=1.
REQ-028 After rst deasserts, the first out_valid SHALL occur exactly LAT cycles after the first accepted sample.

Structure
REQ-029 Package fixedpoint SHALL hold the following shared items.
- LOG2_TABLE[0..31]: log2(1+2^-i) in fixedpoint::number.
- LN2 constant.
- Helper function msb_index (combinational leading-one priority encoder).
REQ-030 A sub-module bkm_log_stage SHALL implement one registered iteration, parameterised by stage index I, carrying x, y, v, k, valid, mode, err and tag.
REQ-031 bkm_log_unit SHALL instantiate STAGES copies of bkm_log_stage in a generate loop.

Verification
REQ-032 1.0 in log2 mode at cycle c -> out_valid exactly at c+LAT, out_log = 0, out_err = 0, tag echoed.
REQ-033 Powers of two:
- 8.0 -> 3.0 exactly.
- 0.5 -> -1.0 exactly.
- 2^-20 -> -20.0 exactly.
REQ-034 3.0 in ln mode -> within 2^-(STAGES-3) of 1.098612.
- Same sample in log2 mode -> within 2^-(STAGES-2) of 1.584963.
REQ-035 Error operands:
- 0 -> out_err = 1, out_log = 0.
- -2.0 -> out_err = 1, out_log = 0.
- The following positive sample is unaffected.
REQ-036 200 random positive samples with random gaps, modes and incrementing tags -> results in order, tags match, bubble pattern identical, every result within REQ-023 tolerance.
REQ-037 Reset asserted with 10 samples in flight -> out_valid stays 0 until LAT cycles after the first post-reset sample.
